mem_region_decoder: RTL and testbench
=====================================

// Module: mem_region_decoder
// PURPOSE
//  Parametrised successor to the S100 Z80 SBC memory decoder: N page-granular chip-select regions plus default RAM.
//  Adds a boot-overlay FSM (ROM also appears at page 0 after reset until first fetch from its home page).
//  Adds per-region wait-state generation, ROM write protection and phantom gating.
//  Sits between the Z80 core bus strobes and the ROM/RAM/VGA-RAM blocks.
// PARAMETERS
//  ADDR_W        16          CPU address width
//  PAGE_W        4           upper address bits compared (page = address[ADDR_W-1 -: PAGE_W])
//  NUM_REGIONS   2           decoded regions; index 0 is highest priority
//  REGION_PAGES  {4'hE,4'hF} packed, region i page = REGION_PAGES[i*PAGE_W +: PAGE_W] (0=ROM F000, 1=VGA E000)
//  REGION_RO     2'b01       bit i set -> region i read-only
//  WAIT_W        3           wait-count width
//  REGION_WAITS  {3'd0,3'd1} packed, wait cycles per region, REGION_WAITS[i*WAIT_W +: WAIT_W]
//  RAM_WAITS     0           wait cycles for default RAM
//  BOOT_REGION   0           region overlaid at BOOT_PAGE while booting
//  BOOT_PAGE     4'h0        overlay page
// PORTS
//  clock         in   1            system clock
//  reset         in   1            asynchronous, active-high reset
//  address       in   ADDR_W       CPU address
//  memread       in   1            memory read strobe, active high
//  memwrite      in   1            memory write strobe, active high
//  n_jorphant    in   1            low = phantom, suppresses ram_cs
//  region_cs     out  NUM_REGIONS  one-hot region select (combinational)
//  ram_cs        out  1            default RAM select (combinational)
//  ready         out  1            high = no wait; low stretches cycle
//  boot_active   out  1            high while overlay is armed
//  wp_err        out  1            one-clock pulse on write to read-only region
// BEHAVIOUR
//  Reset values: boot_active=1, ready=1, wp_err=0, wait counter=0, strobe_q=0.
//  Outputs with no strobe: region_cs=0, ram_cs=0.
//  hit[i] = (page==REGION_PAGES[i]) | (boot_active & i==BOOT_REGION & page==BOOT_PAGE).
//  sel = lowest i with hit[i]. No region hit and strobe active -> default RAM.
//  region_cs[sel]=1 when (memread | (memwrite & ~REGION_RO[sel])). Writes to RO regions select nothing.
//  ram_cs = no hit & (memread|memwrite) & n_jorphant. Phantom never masks region_cs.
//  Boot FSM, states BOOT -> RUN:
//   leave BOOT on the clock edge where memread=1 and page==REGION_PAGES[BOOT_REGION]
//   (the post-reset jump has landed). RUN is terminal until reset.
//   Overlay writes at BOOT_PAGE while in BOOT: RO rules apply (wp_err, no cs).
//  Access start: start = (memread|memwrite) & ~strobe_q; strobe_q registers (memread|memwrite).
//  Wait sequence (N = selected region's wait count, RAM_WAITS if default):
//   ready = ~(start & N!=0) & (cnt==0). ready is low for exactly N clocks beginning with the start cycle.
//   On start with N!=0: cnt loads N-1. Each following clock decrements while cnt!=0.
//   N=0: ready stays high, no latency.
//   Strobe drops while cnt!=0: cnt clears on next edge (abort). New access needs a new start edge.
//   Strobe held across accesses (no low gap): no new start, no extra waits.
//   Address changes mid-access are ignored by the counter; cs tracks address combinationally.
//  wp_err: registered, =1 the cycle after a start where memwrite targets an RO region; else 0.
//  Reset asserted mid-wait or mid-boot: everything returns to reset values asynchronously and overlay re-arms.
//  Widths: page compare exact PAGE_W bits. cnt is WAIT_W bits; an all-ones count is legal (2^WAIT_W-1 waits).
// STRUCTURE
//  Package mem_dec_pkg:
//   PAGE_W and WAIT_W defaults
//   region index localparams (RGN_ROM=0, RGN_VGA=1)
//   boot state encoding (BOOT/RUN)
//  Sub-module wait_state_gen (start, strobe, count in -> ready): owns the counter and abort logic.
//  Page match, priority select, boot FSM and wp_err stay in the top level.
// TESTING
//  1 Reset, memread at 0x0000 -> region_cs=2'b01, ram_cs=0, boot_active=1; memread at 0x0005 same.
//  2 Boot exit: memread at 0xF003 -> boot_active=0 next edge; then memread at 0x0000 -> ram_cs=1, region_cs=0.
//  3 memwrite at 0xF100 in RUN -> region_cs=0, ram_cs=0, wp_err=1 for exactly one clock after start.
//  4 memread at 0xE010 with REGION_WAITS[1]=1 -> region_cs=2'b10, ready low 1 clock; set 7 -> ready low 7 clocks.
//  5 Abort and phantom: strobe dropped after 2 of 5 waits -> ready=1 next clock, cnt=0.
//    n_jorphant=0 with memread at 0x4000 -> ram_cs=0, ready=1.
//  6 reset pulse mid-wait in RUN -> ready=1, boot_active=1 immediately; memread 0x0000 -> region_cs=2'b01.

Source files
------------

// File: rtl/mem_dec_pkg.sv
// Shared constants for the memory region decoder: default widths,
// well-known region indices and the boot-overlay state encoding.
package mem_dec_pkg;

    localparam int PAGE_W_DEF = 4;
    localparam int WAIT_W_DEF = 3;

    localparam int RGN_ROM = 0;
    localparam int RGN_VGA = 1;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } boot_state_t;

endpackage

// File: rtl/mem_region_decoder_if.sv
// CPU-side bus of the region decoder: address and strobes in, selects and
// status back out. The master modport is the CPU; the slave is the decoder.
interface mem_region_decoder_if #(
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 2
);
    logic [ADDR_W-1:0]      address;
    logic                   memread;
    logic                   memwrite;
    logic                   n_jorphant;
    logic [NUM_REGIONS-1:0] region_cs;
    logic                   ram_cs;
    logic                   ready;
    logic                   boot_active;
    logic                   wp_err;

    modport master (
        output address, memread, memwrite, n_jorphant,
        input  region_cs, ram_cs, ready, boot_active, wp_err
    );

    modport slave (
        input  address, memread, memwrite, n_jorphant,
        output region_cs, ram_cs, ready, boot_active, wp_err
    );
endinterface

// File: rtl/mem_region_decoder_wait_state_gen.sv
// Wait-state counter: stretches an access by `count` clocks starting with the
// start cycle, and abandons the remaining waits if the strobe drops early.
module wait_state_gen #(
    parameter int WAIT_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              strobe,
    input  logic [WAIT_W-1:0] count,
    output logic              ready
);
    logic [WAIT_W-1:0] cnt_reg;
    logic [WAIT_W-1:0] cnt_next;
    logic              load;

    // The start cycle itself is the first wait, so the counter holds one fewer.
    assign load = start && (count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = count - 1'b1;
        end else if (!strobe) begin
            cnt_next = '0;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    assign ready = !load && (cnt_reg == '0);

endmodule

// File: rtl/mem_region_decoder.sv
// Page-granular chip-select decoder with boot overlay, per-region wait states,
// read-only write protection and phantom gating of the default RAM.
module mem_region_decoder
    import mem_dec_pkg::*;
#(
    parameter int                           ADDR_W       = 16,
    parameter int                           PAGE_W       = PAGE_W_DEF,
    parameter int                           NUM_REGIONS  = 2,
    parameter logic [NUM_REGIONS*PAGE_W-1:0] REGION_PAGES = {4'hE, 4'hF},
    parameter logic [NUM_REGIONS-1:0]       REGION_RO    = 2'b01,
    parameter int                           WAIT_W       = WAIT_W_DEF,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAITS = {3'd0, 3'd1},
    parameter int                           RAM_WAITS    = 0,
    parameter int                           BOOT_REGION  = RGN_ROM,
    parameter logic [PAGE_W-1:0]            BOOT_PAGE    = 4'h0
) (
    input logic                  clock,
    input logic                  reset,
    mem_region_decoder_if.slave  bus
);
    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [PAGE_W-1:0] BOOT_HOME = REGION_PAGES[BOOT_REGION*PAGE_W +: PAGE_W];

    logic [PAGE_W-1:0]      page;
    logic [NUM_REGIONS-1:0] hit;
    logic [SEL_W-1:0]       sel;
    logic                   any_hit;
    logic                   sel_ro;
    logic [WAIT_W-1:0]      sel_waits;
    logic [WAIT_W-1:0]      wait_n;
    logic [NUM_REGIONS-1:0] region_cs_next;
    logic                   strobe;
    logic                   strobe_q_reg;
    logic                   start;
    logic                   wp_err_reg;
    logic                   boot_active;
    logic                   ready;
    boot_state_t            state_reg;
    boot_state_t            state_next;
    logic                   addr_unused;

    assign page        = bus.address[ADDR_W-1 -: PAGE_W];
    assign addr_unused = ^bus.address[ADDR_W-PAGE_W-1:0];
    assign strobe      = bus.memread || bus.memwrite;
    assign start       = strobe && !strobe_q_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
            localparam bit IS_BOOT = (gi == BOOT_REGION);
            assign hit[gi] = (page == REGION_PAGES[gi*PAGE_W +: PAGE_W])
                          || (IS_BOOT && boot_active && (page == BOOT_PAGE));
        end
    endgenerate

    // Scan from the top down so the lowest-index hit wins.
    always_comb begin
        sel     = '0;
        any_hit = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = SEL_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    assign sel_ro    = REGION_RO[sel];
    assign sel_waits = REGION_WAITS[int'(sel)*WAIT_W +: WAIT_W];
    assign wait_n    = any_hit ? sel_waits : WAIT_W'(RAM_WAITS);

    always_comb begin
        region_cs_next = '0;
        if (any_hit && (bus.memread || (bus.memwrite && !sel_ro))) begin
            region_cs_next[sel] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_q_reg <= 1'b0;
            wp_err_reg   <= 1'b0;
        end else begin
            strobe_q_reg <= strobe;
            wp_err_reg   <= start && bus.memwrite && any_hit && sel_ro;
        end
    end

    // Boot overlay FSM: state register, next-state and output processes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_BOOT && bus.memread && page == BOOT_HOME) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        boot_active = (state_reg == ST_BOOT);
    end

    wait_state_gen #(
        .WAIT_W (WAIT_W)
    ) u_wait (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .strobe (strobe),
        .count  (wait_n),
        .ready  (ready)
    );

    assign bus.region_cs   = region_cs_next;
    assign bus.ram_cs      = !any_hit && strobe && bus.n_jorphant;
    assign bus.ready       = ready;
    assign bus.boot_active = boot_active;
    assign bus.wp_err      = wp_err_reg;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Directed bench for the region decoder: DUT A has a 1-wait VGA region and
// zero-wait RAM, DUT B a 7-wait VGA region and 5-wait RAM.
module tb_mem_region_decoder;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    mem_region_decoder_if #(.ADDR_W(16), .NUM_REGIONS(2)) if_a ();
    mem_region_decoder_if #(.ADDR_W(16), .NUM_REGIONS(2)) if_b ();

    mem_region_decoder #(
        .ADDR_W(16), .PAGE_W(4), .NUM_REGIONS(2),
        .REGION_PAGES({4'hE, 4'hF}), .REGION_RO(2'b01), .WAIT_W(3),
        .REGION_WAITS({3'd1, 3'd0}), .RAM_WAITS(0),
        .BOOT_REGION(0), .BOOT_PAGE(4'h0)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (if_a)
    );

    mem_region_decoder #(
        .ADDR_W(16), .PAGE_W(4), .NUM_REGIONS(2),
        .REGION_PAGES({4'hE, 4'hF}), .REGION_RO(2'b01), .WAIT_W(3),
        .REGION_WAITS({3'd7, 3'd0}), .RAM_WAITS(5),
        .BOOT_REGION(0), .BOOT_PAGE(4'h0)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [15:0] addr, input logic rd, input logic wr, input logic nj);
        if_a.address    = addr;
        if_a.memread    = rd;
        if_a.memwrite   = wr;
        if_a.n_jorphant = nj;
    endtask

    task automatic drive_b(input logic [15:0] addr, input logic rd, input logic wr);
        if_b.address    = addr;
        if_b.memread    = rd;
        if_b.memwrite   = wr;
        if_b.n_jorphant = 1'b1;
    endtask

    task automatic test_reset();
        n_vec++; if (if_a.ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", if_a.ready); end
        n_vec++; if (if_a.wp_err !== 1'b0) begin n_bad++; $display("FAIL rst_wp_err: got %b want 0", if_a.wp_err); end
        n_vec++; if (if_a.boot_active !== 1'b1) begin n_bad++; $display("FAIL rst_boot: got %b want 1", if_a.boot_active); end
        n_vec++; if (if_a.region_cs !== 2'b00 || if_a.ram_cs !== 1'b0) begin n_bad++; $display("FAIL idle_cs: got %b/%b want 00/0", if_a.region_cs, if_a.ram_cs); end
        drive_a(16'h0000, 1'b1, 1'b0, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b01) begin n_bad++; $display("FAIL overlay_cs_0000: got %b want 01", if_a.region_cs); end
        n_vec++; if (if_a.ram_cs !== 1'b0) begin n_bad++; $display("FAIL overlay_ram_0000: got %b want 0", if_a.ram_cs); end
        drive_a(16'h0005, 1'b1, 1'b0, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b01 || if_a.ram_cs !== 1'b0) begin n_bad++; $display("FAIL overlay_cs_0005: got %b/%b want 01/0", if_a.region_cs, if_a.ram_cs); end
        tick();
        n_vec++; if (if_a.boot_active !== 1'b1) begin n_bad++; $display("FAIL overlay_boot_held: got %b want 1", if_a.boot_active); end
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_overlay_write();
        drive_a(16'h0000, 1'b0, 1'b1, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b00 || if_a.ram_cs !== 1'b0) begin n_bad++; $display("FAIL ovl_wr_cs: got %b/%b want 00/0", if_a.region_cs, if_a.ram_cs); end
        tick();
        n_vec++; if (if_a.wp_err !== 1'b1) begin n_bad++; $display("FAIL ovl_wr_wp_err: got %b want 1", if_a.wp_err); end
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        n_vec++; if (if_a.wp_err !== 1'b0) begin n_bad++; $display("FAIL ovl_wr_wp_clear: got %b want 0", if_a.wp_err); end
    endtask

    task automatic test_boot_exit();
        drive_a(16'hF003, 1'b1, 1'b0, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b01 || if_a.boot_active !== 1'b1) begin n_bad++; $display("FAIL boot_home: got cs %b boot %b want 01/1", if_a.region_cs, if_a.boot_active); end
        tick();
        n_vec++; if (if_a.boot_active !== 1'b0) begin n_bad++; $display("FAIL boot_exit: got %b want 0", if_a.boot_active); end
        drive_a(16'h0000, 1'b1, 1'b0, 1'b1);
        #1;
        n_vec++; if (if_a.ram_cs !== 1'b1 || if_a.region_cs !== 2'b00) begin n_bad++; $display("FAIL run_0000: got ram %b cs %b want 1/00", if_a.ram_cs, if_a.region_cs); end
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_write_protect();
        drive_a(16'hF100, 1'b0, 1'b1, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b00 || if_a.ram_cs !== 1'b0) begin n_bad++; $display("FAIL wp_cs: got %b/%b want 00/0", if_a.region_cs, if_a.ram_cs); end
        n_vec++; if (if_a.wp_err !== 1'b0) begin n_bad++; $display("FAIL wp_start_cycle: got %b want 0", if_a.wp_err); end
        tick();
        n_vec++; if (if_a.wp_err !== 1'b1) begin n_bad++; $display("FAIL wp_pulse: got %b want 1", if_a.wp_err); end
        tick();
        n_vec++; if (if_a.wp_err !== 1'b0) begin n_bad++; $display("FAIL wp_one_clock: got %b want 0", if_a.wp_err); end
        drive_a(16'h4000, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++; if (if_a.ram_cs !== 1'b1 || if_a.wp_err !== 1'b0) begin n_bad++; $display("FAIL ram_write: got ram %b wp %b want 1/0", if_a.ram_cs, if_a.wp_err); end
        drive_a(16'h4000, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_wait_states();
        int lows;
        drive_a(16'hE010, 1'b1, 1'b0, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b10) begin n_bad++; $display("FAIL vga_cs: got %b want 10", if_a.region_cs); end
        n_vec++; if (if_a.ready !== 1'b0) begin n_bad++; $display("FAIL vga1_start: got %b want 0", if_a.ready); end
        tick();
        n_vec++; if (if_a.ready !== 1'b1) begin n_bad++; $display("FAIL vga1_done: got %b want 1", if_a.ready); end
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive_b(16'hE010, 1'b1, 1'b0);
        #1;
        n_vec++; if (if_b.region_cs !== 2'b10) begin n_bad++; $display("FAIL vga7_cs: got %b want 10", if_b.region_cs); end
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            if (if_b.ready === 1'b0) lows++;
            else break;
            tick();
        end
        n_vec++; if (lows != 7) begin n_bad++; $display("FAIL vga7_waits: got %0d want 7", lows); end
        drive_b(16'h0000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_abort_phantom();
        int lows;
        drive_b(16'h4000, 1'b1, 1'b0);
        #1;
        n_vec++; if (if_b.ready !== 1'b0 || if_b.ram_cs !== 1'b1) begin n_bad++; $display("FAIL abort_start: got rdy %b ram %b want 0/1", if_b.ready, if_b.ram_cs); end
        tick();
        n_vec++; if (if_b.ready !== 1'b0) begin n_bad++; $display("FAIL abort_wait2: got %b want 0", if_b.ready); end
        tick();
        drive_b(16'h4000, 1'b0, 1'b0);
        tick();
        n_vec++; if (if_b.ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", if_b.ready); end
        drive_b(16'h4000, 1'b1, 1'b0);
        #1;
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            if (if_b.ready === 1'b0) lows++;
            else break;
            tick();
        end
        n_vec++; if (lows != 5) begin n_bad++; $display("FAIL abort_restart_waits: got %0d want 5", lows); end
        drive_b(16'h4000, 1'b0, 1'b0);
        tick();
        drive_a(16'h4000, 1'b1, 1'b0, 1'b0);
        #1;
        n_vec++; if (if_a.ram_cs !== 1'b0 || if_a.ready !== 1'b1) begin n_bad++; $display("FAIL phantom_ram: got ram %b rdy %b want 0/1", if_a.ram_cs, if_a.ready); end
        drive_a(16'hF000, 1'b1, 1'b0, 1'b0);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b01) begin n_bad++; $display("FAIL phantom_rom: got %b want 01", if_a.region_cs); end
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        int lows;
        drive_b(16'h4000, 1'b1, 1'b0);
        #1;
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            if (if_b.ready === 1'b0) lows++;
            else break;
            tick();
        end
        n_vec++; if (lows != 5) begin n_bad++; $display("FAIL b2b_first_waits: got %0d want 5", lows); end
        drive_b(16'hE010, 1'b1, 1'b0);
        #1;
        n_vec++; if (if_b.ready !== 1'b1 || if_b.region_cs !== 2'b10) begin n_bad++; $display("FAIL b2b_held: got rdy %b cs %b want 1/10", if_b.ready, if_b.region_cs); end
        tick();
        n_vec++; if (if_b.ready !== 1'b1) begin n_bad++; $display("FAIL b2b_no_wait: got %b want 1", if_b.ready); end
        drive_b(16'h0000, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive_b(16'hF000, 1'b1, 1'b0);
        tick();
        drive_b(16'h0000, 1'b0, 1'b0);
        tick();
        n_vec++; if (if_b.boot_active !== 1'b0) begin n_bad++; $display("FAIL b_run: got %b want 0", if_b.boot_active); end
        drive_b(16'hE010, 1'b1, 1'b0);
        tick();
        tick();
        n_vec++; if (if_b.ready !== 1'b0) begin n_bad++; $display("FAIL mid_wait: got %b want 0", if_b.ready); end
        #2;
        reset = 1'b1;
        drive_b(16'h0000, 1'b0, 1'b0);
        #1;
        n_vec++; if (if_b.ready !== 1'b1 || if_b.boot_active !== 1'b1) begin n_bad++; $display("FAIL async_rst: got rdy %b boot %b want 1/1", if_b.ready, if_b.boot_active); end
        n_vec++; if (if_a.boot_active !== 1'b1) begin n_bad++; $display("FAIL async_rst_a: got %b want 1", if_a.boot_active); end
        tick();
        reset = 1'b0;
        drive_a(16'h0000, 1'b1, 1'b0, 1'b1);
        #1;
        n_vec++; if (if_a.region_cs !== 2'b01) begin n_bad++; $display("FAIL rearm_cs: got %b want 01", if_a.region_cs); end
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        drive_a(16'h0000, 1'b0, 1'b0, 1'b1);
        drive_b(16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        test_reset();
        test_overlay_write();
        test_boot_exit();
        test_write_protect();
        test_wait_states();
        test_abort_phantom();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
